// File: rtl/lcd_rst_pkg.sv
// Shared types and constants for the LCD panel reset sequencer.
package lcd_rst_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_LOW   = 3'd1,
        HOLD_LOW = 3'd2,
        WR_HIGH  = 3'd3,
        RD_BACK  = 3'd4,
        SETTLE   = 3'd5,
        DONE     = 3'd6
    } lcd_rst_state_t;

    localparam logic PIN_LOW  = 1'b0;
    localparam logic PIN_HIGH = 1'b1;

    localparam int unsigned PIO_ADDR_DEFAULT = 0;
    localparam int unsigned AV_ADDR_W        = 2;
    localparam int unsigned AV_DATA_W        = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rst_delay_cnt.sv
// Loadable down-counter that saturates at zero; shared by both delay states.
module lcd_rst_delay_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_rst_seq_master.sv
// Avalon-MM master that pulses the LCD reset PIO low for a timed interval,
// verifies the pin came back high, waits a settle time and reports done.
module lcd_rst_seq_master
    import lcd_rst_pkg::*;
#(
    parameter int unsigned LOW_CYCLES    = 1000,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned PIO_ADDR      = PIO_ADDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [AV_ADDR_W-1:0] address,
    output logic                 chipselect,
    output logic                 write_n,
    output logic [AV_DATA_W-1:0] writedata,
    input  logic [AV_DATA_W-1:0] readdata,
    input  logic                 waitrequest,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned CNT_W = $clog2(max_u(LOW_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0]     LOW_LOAD    = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [AV_ADDR_W-1:0] ADDR        = AV_ADDR_W'(PIO_ADDR);

    lcd_rst_state_t        state_q, state_d;
    logic                  chipselect_q, chipselect_d;
    logic                  write_n_q, write_n_d;
    logic [AV_ADDR_W-1:0]  address_q, address_d;
    logic [AV_DATA_W-1:0]  writedata_q, writedata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_value;
    logic                  cnt_zero;
    logic                  unused_readdata;

    // Only the pin level bit is meaningful on readback.
    assign unused_readdata = ^readdata[AV_DATA_W-1:1];

    lcd_rst_delay_cnt #(
        .WIDTH(CNT_W)
    ) u_delay_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .zero      (cnt_zero)
    );

    // Next state, then outputs decoded from the next state so they register in step with it.
    always_comb begin
        state_d        = state_q;
        error_d        = error_q;
        cnt_load       = 1'b0;
        cnt_load_value = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR_LOW;
                    error_d = 1'b0;
                end
            end
            WR_LOW: begin
                if (!waitrequest) begin
                    state_d        = HOLD_LOW;
                    cnt_load       = 1'b1;
                    cnt_load_value = LOW_LOAD;
                end
            end
            HOLD_LOW: begin
                if (cnt_zero) begin
                    state_d = WR_HIGH;
                end
            end
            WR_HIGH: begin
                if (!waitrequest) begin
                    state_d = RD_BACK;
                end
            end
            RD_BACK: begin
                if (!waitrequest) begin
                    state_d        = SETTLE;
                    cnt_load       = 1'b1;
                    cnt_load_value = SETTLE_LOAD;
                    if (readdata[0] != PIN_HIGH) begin
                        error_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        chipselect_d = (state_d == WR_LOW) || (state_d == WR_HIGH) || (state_d == RD_BACK);
        write_n_d    = !((state_d == WR_LOW) || (state_d == WR_HIGH));
        address_d    = chipselect_d ? ADDR : '0;
        writedata_d  = AV_DATA_W'((state_d == WR_HIGH) ? PIN_HIGH : PIN_LOW);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            address_q    <= '0;
            writedata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            chipselect_q <= chipselect_d;
            write_n_q    <= write_n_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign chipselect = chipselect_q;
    assign write_n    = write_n_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_lcd_rst_seq_master.sv
// Scoreboard bench for lcd_rst_seq_master: expected bus/done events are queued
// with their cycle offsets and matched by per-DUT monitors.
module tb_lcd_rst_seq_master;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  data;
        logic [15:0] cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        waitrequest_a;
    logic        force_rd0;
    logic [1:0]  addr_a, addr_b;
    logic        cs_a, cs_b, wn_a, wn_b;
    logic [31:0] wd_a, wd_b, rd_a, rd_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic        pin_a, pin_b;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_rst_seq_master #(.LOW_CYCLES(4), .SETTLE_CYCLES(6), .PIO_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .address(addr_a),
        .chipselect(cs_a), .write_n(wn_a), .writedata(wd_a), .readdata(rd_a),
        .waitrequest(waitrequest_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    lcd_rst_seq_master #(.LOW_CYCLES(1), .SETTLE_CYCLES(1), .PIO_ADDR(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .address(addr_b),
        .chipselect(cs_b), .write_n(wn_b), .writedata(wd_b), .readdata(rd_b),
        .waitrequest(1'b0), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // PIO slave models: pin resets high, zero read latency.
    always @(posedge clk) begin
        if (reset) pin_a <= 1'b1;
        else if (cs_a && !wn_a && !waitrequest_a) pin_a <= wd_a[0];
        if (reset) pin_b <= 1'b1;
        else if (cs_b && !wn_b) pin_b <= wd_b[0];
    end
    assign rd_a = {31'd0, force_rd0 ? 1'b0 : pin_a};
    assign rd_b = {31'd0, pin_b};

    function automatic ev_t mk(input logic [1:0] k, input logic [1:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = 16'(c);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_ev(input string nm, input int have, input ev_t exp, input ev_t act);
        n_assert++;
        if (have == 0) begin
            n_fail++;
            $display("FAIL %s unexpected event: kind=%0d data=%0d cyc=%0d", nm, act.kind, act.data, act.cyc);
        end else if (act !== exp) begin
            n_fail++;
            $display("FAIL %s event: got kind=%0d data=%0d cyc=%0d, expected kind=%0d data=%0d cyc=%0d",
                     nm, act.kind, act.data, act.cyc, exp.kind, exp.data, exp.cyc);
        end
    endtask

    // Monitors: one event per accepted bus cycle or done pulse.
    always @(negedge clk) begin
        ev_t act, exp;
        int  have;
        if ((cs_a && !waitrequest_a) || done_a) begin
            if (done_a) act = mk(EV_DONE, {1'b0, err_a}, cyc - t0);
            else if (wn_a) act = mk(EV_RD, {1'b0, |addr_a}, cyc - t0);
            else act = mk(EV_WR, {|wd_a[31:1], wd_a[0]}, cyc - t0);
            have = q_a.size();
            exp  = (have != 0) ? q_a.pop_front() : '0;
            cmp_ev("dut_a", have, exp, act);
        end
        if (cs_b || done_b) begin
            if (done_b) act = mk(EV_DONE, {1'b0, err_b}, cyc - t0);
            else if (wn_b) act = mk(EV_RD, {1'b0, |addr_b}, cyc - t0);
            else act = mk(EV_WR, {|wd_b[31:1], wd_b[0]}, cyc - t0);
            have = q_b.size();
            exp  = (have != 0) ? q_b.pop_front() : '0;
            cmp_ev("dut_b", have, exp, act);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Begins cycle 0 of a sequence with start held for this cycle only.
    task automatic begin_a();
        step();
        start_a = 1'b1;
        t0 = cyc;
        step();
        start_a = 1'b0;
    endtask

    task automatic push_normal_a(input logic err_exp);
        q_a.push_back(mk(EV_WR, 2'b00, 1));
        q_a.push_back(mk(EV_WR, 2'b01, 6));
        q_a.push_back(mk(EV_RD, 2'b00, 7));
        q_a.push_back(mk(EV_DONE, {1'b0, err_exp}, 14));
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        waitrequest_a = 1'b0; force_rd0 = 1'b0;
        step(); step();
        chk("rst_cs", 32'(cs_a), 32'd0);
        chk("rst_wn", 32'(wn_a), 32'd1);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_wd", wd_a, 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        step();

        // Nominal sequence.
        push_normal_a(1'b0);
        begin_a();
        chk("busy_c1", 32'(busy_a), 32'd1);
        repeat (20) step();
        chk("idle_after_seq", 32'(busy_a), 32'd0);
        chk("pin_high", 32'(pin_a), 32'd1);

        // Three stall cycles during WR_LOW.
        q_a.push_back(mk(EV_WR, 2'b00, 4));
        q_a.push_back(mk(EV_WR, 2'b01, 9));
        q_a.push_back(mk(EV_RD, 2'b00, 10));
        q_a.push_back(mk(EV_DONE, 2'b00, 17));
        begin_a();
        waitrequest_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("stall_cs_c%0d", i), 32'(cs_a), 32'd1);
            chk($sformatf("stall_wn_c%0d", i), 32'(wn_a), 32'd0);
            chk($sformatf("stall_wd_c%0d", i), wd_a, 32'd0);
            if (i == 3) begin
                step();
                waitrequest_a = 1'b0;
            end else begin
                step();
            end
        end
        repeat (20) step();

        // Readback returns 0: error sets and sticks until the next start.
        force_rd0 = 1'b1;
        push_normal_a(1'b1);
        begin_a();
        repeat (7) step();
        chk("err_after_rd", 32'(err_a), 32'd1);
        repeat (12) step();
        force_rd0 = 1'b0;
        chk("err_sticky", 32'(err_a), 32'd1);
        push_normal_a(1'b0);
        begin_a();
        chk("err_cleared_c1", 32'(err_a), 32'd0);
        repeat (20) step();

        // start while busy is ignored.
        push_normal_a(1'b0);
        begin_a();
        step(); step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (20) step();

        // Reset during HOLD_LOW aborts without done.
        q_a.push_back(mk(EV_WR, 2'b00, 1));
        begin_a();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_cs", 32'(cs_a), 32'd0);
        chk("abort_wn", 32'(wn_a), 32'd1);
        chk("abort_addr", 32'(addr_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        repeat (20) step();
        chk("abort_pin", 32'(pin_a), 32'd1);
        push_normal_a(1'b0);
        begin_a();
        repeat (20) step();

        // Minimum delays on the second instance.
        q_b.push_back(mk(EV_WR, 2'b00, 1));
        q_b.push_back(mk(EV_WR, 2'b01, 3));
        q_b.push_back(mk(EV_RD, 2'b00, 4));
        q_b.push_back(mk(EV_DONE, 2'b00, 6));
        step();
        start_b = 1'b1;
        t0 = cyc;
        step();
        start_b = 1'b0;
        repeat (12) step();
        chk("b_idle", 32'(busy_b), 32'd0);

        chk("q_a_drained", 32'(q_a.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
